four_bit_2src_arb_reg: RTL and testbench
========================================

Name: four_bit_2src_arb_reg

Overview:
- Upstream controller and downstream register for the 4-bit 2:1 mux. It arbitrates between two 4-bit producers (A, B) using valid/ready handshakes.
- Drives the mux select, `sel`. Captures the selected word into a one-entry output register with a valid/ready handshake to the consumer.
- Round-robin fairness on conflict; full throughput, one word per cycle, when the consumer is always ready.

Parameters:
- INIT_PRIO, 1'b0, source favoured on the first conflict after reset (0=A, 1=B).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- a_valid  input  1  source A word available
- a_data  input  4  source A word
- a_ready  output  1  source A word accepted this cycle
- b_valid  input  1  source B word available
- b_data  input  4  source B word
- b_ready  output  1  source B word accepted this cycle
- sel  output  1  mux select (0 passes A, 1 passes B)
- out_valid  output  1  output register holds a word
- out_data  output  4  registered selected word
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset: asynchronous assert, synchronous-safe release; clears all state regardless of operation in flight.
  - Reset values: out_valid=0, out_data=4'h0, prio=INIT_PRIO, last_sel=0, hence sel=0; a_ready=b_ready=0.
  - Any held word is discarded.
- Output register states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - space = !out_valid || out_ready (combinational).
- Grant, combinational:
  - only a_valid → A; only b_valid → B; both → prio (0=A, 1=B).
  - neither valid → no grant; sel = last_sel.
- sel = granted source when a grant exists, else last_sel. sel is always defined, never X.
- Ready outputs:
  - a_ready = space && grant==A; b_ready = space && grant==B. At most one is high per cycle.
  - Sources must not make valid depend on ready. Ready may depend on the other source's valid.
- Transfer: occurs when (a_valid && a_ready) or (b_valid && b_ready). At the next edge:
  - out_data <= mux output (a_data if sel=0, else b_data); out_valid <= 1; last_sel <= sel.
  - prio <= ~granted source, i.e. the loser of this grant wins the next conflict. prio updates on every transfer, conflict or not.
- No transfer and out_ready && out_valid: out_valid <= 0; out_data holds its value.
- FULL && !out_ready: out_valid, out_data, prio and last_sel all hold; a_ready=b_ready=0 (backpressure).
- Simultaneous drain and fill (FULL, out_ready=1, a grant exists): the new word replaces the old word in the same edge; out_valid stays 1. No bubble.
- Latency: one cycle from an accepted input to out_valid.
- Throughput: one word per cycle.
- Data width: fixed 4 bits. No arithmetic on data.

Optional Feature:
- Macro: ARB_GRANT_COUNT_EN.
- Defined:
  - Adds ports a_grant_cnt and b_grant_cnt, each an output of 8 bits.
  - Each counts transfers from its source and saturates at 8'hFF, with no wrap.
  - Reset value is 0. Each increments on the same edge as its source's transfer.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package arb_pkg holds:
  - constants SRC_A=1'b0, SRC_B=1'b1;
  - DATA_W=4;
  - GRANT_CNT_W=8 and GRANT_CNT_MAX=8'hFF.
- Natural sub-module: rr_arbiter_2, a combinational grant plus prio register with inputs req[1:0], advance, clk, reset_n and output gnt.
- The datapath instantiates four_bit_2_1_mux with s=sel, then the output register.

Test Plan:
- Reset: assert reset_n=0 mid-transfer with out_valid=1, out_data=4'h9 → out_valid=0, out_data=4'h0 and sel=0 immediately (asynchronous); after release, a_ready=b_ready=0 until a source is valid.
- Single source: a_valid=1, a_data=4'h5, out_ready=1 → a_ready=1, sel=0; next cycle out_valid=1, out_data=4'h5.
- Conflict, round-robin: both sources valid every cycle, a_data=4'h3, b_data=4'hC, out_ready=1, INIT_PRIO=0 → out_data sequence 3,C,3,C; sel toggles 0,1,0,1.
- Backpressure: FULL with out_data=4'hA, out_ready=0 for 3 cycles, b_valid=1 → b_ready=0 and out_data stays 4'hA; on out_ready=1 the B word loads in the same edge with no bubble.
- Idle hold: after a B transfer, drop both valids → sel stays 1 and out_valid drops after one out_ready cycle.
- ARB_GRANT_COUNT_EN: 300 consecutive A transfers → a_grant_cnt=8'hFF and b_grant_cnt=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the two-source 4-bit arbiter and output register.
// Grant counter width and ceiling apply only when ARB_GRANT_COUNT_EN is defined.
package arb_pkg;

   localparam int unsigned DATA_W      = 4;
   localparam int unsigned GRANT_CNT_W = 8;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = 8'hFF;

   // Saturating increment used by the per-source grant counters.
   function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
      return (v == GRANT_CNT_MAX) ? v : v + GRANT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/four_bit_2_1_mux.sv
// 4-bit 2:1 multiplexer: s=0 passes a, s=1 passes b.
module four_bit_2_1_mux
   import arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              s,
   output logic [DATA_W-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter: combinational grant index plus a priority
// flop that hands the next conflict to the loser of the last advanced grant.
module rr_arbiter_2
   import arb_pkg::*;
#(
   parameter logic INIT_PRIO = 1'b0
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       gnt
);

   logic prio_q;
   logic prio_d;

   // req[0] is source A, req[1] is source B; prio breaks the tie.
   always_comb begin
      gnt    = SRC_A;
      prio_d = prio_q;
      if (req[1] && !req[0]) begin
         gnt = SRC_B;
      end else if (req[1] && req[0]) begin
         gnt = prio_q;
      end
      if (advance) begin
         prio_d = ~gnt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_q <= INIT_PRIO;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/four_bit_2src_arb_reg.sv
// Arbitrates two valid/ready 4-bit sources into a one-entry output register.
// Define ARB_GRANT_COUNT_EN to add saturating per-source transfer counters.
module four_bit_2src_arb_reg
   import arb_pkg::*;
#(
   parameter logic INIT_PRIO = 1'b0
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   a_valid,
   input  logic [DATA_W-1:0]      a_data,
   output logic                   a_ready,
   input  logic                   b_valid,
   input  logic [DATA_W-1:0]      b_data,
   output logic                   b_ready,
   output logic                   sel,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
`ifdef ARB_GRANT_COUNT_EN
   output logic [GRANT_CNT_W-1:0] a_grant_cnt,
   output logic [GRANT_CNT_W-1:0] b_grant_cnt,
`endif
   input  logic                   out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              last_sel_q,  last_sel_d;

   logic              space;
   logic              any_req;
   logic              gnt;
   logic              xfer;
   logic [DATA_W-1:0] mux_y;

   rr_arbiter_2 #(
      .INIT_PRIO (INIT_PRIO)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({b_valid, a_valid}),
      .advance (xfer),
      .gnt     (gnt)
   );

   four_bit_2_1_mux u_mux (
      .a (a_data),
      .b (b_data),
      .s (sel),
      .y (mux_y)
   );

   // Handshake: a word moves whenever some source is valid and the register has room.
   always_comb begin
      space   = !out_valid_q || out_ready;
      any_req = a_valid || b_valid;
      sel     = any_req ? gnt : last_sel_q;
      xfer    = space && any_req;
      a_ready = xfer && (gnt == SRC_A);
      b_ready = xfer && (gnt == SRC_B);
   end

   // Output register: fill (possibly replacing a draining word), drain, or hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      last_sel_d  = last_sel_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_y;
         last_sel_d  = sel;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         last_sel_q  <= SRC_A;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         last_sel_q  <= last_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef ARB_GRANT_COUNT_EN
   logic [GRANT_CNT_W-1:0] a_cnt_q, a_cnt_d;
   logic [GRANT_CNT_W-1:0] b_cnt_q, b_cnt_d;

   always_comb begin
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      if (a_ready) begin
         a_cnt_d = sat_inc(a_cnt_q);
      end
      if (b_ready) begin
         b_cnt_d = sat_inc(b_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
      end else begin
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
      end
   end

   assign a_grant_cnt = a_cnt_q;
   assign b_grant_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_four_bit_2src_arb_reg.sv
// Directed self-checking bench for four_bit_2src_arb_reg (counter checks when
// ARB_GRANT_COUNT_EN is defined).
module tb_four_bit_2src_arb_reg;
   import arb_pkg::*;

   logic              clk;
   logic              reset_n;
   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              sel;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
`ifdef ARB_GRANT_COUNT_EN
   logic [GRANT_CNT_W-1:0] a_grant_cnt;
   logic [GRANT_CNT_W-1:0] b_grant_cnt;
`endif

   int n_chk;
   int n_err;

   four_bit_2src_arb_reg #(.INIT_PRIO(1'b0)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
`ifdef ARB_GRANT_COUNT_EN
      .a_grant_cnt (a_grant_cnt),
      .b_grant_cnt (b_grant_cnt),
`endif
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      #2 reset_n = 1'b0;
      #2 reset_n = 1'b1;
   endtask

   localparam logic [3:0] CONF_DATA [4] = '{4'h3, 4'hC, 4'h3, 4'hC};

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      a_data = '0; b_data = '0; out_ready = 1'b0;
      tick();
      chk("rst_out_valid", 8'(out_valid), 8'h0);
      chk("rst_sel", 8'(sel), 8'h0);
      reset_n = 1'b1;

      // Load 9 into the register, then reset while it is held.
      a_valid = 1'b1; a_data = 4'h9;
      tick();
      chk("pre_rst_valid", 8'(out_valid), 8'h1);
      chk("pre_rst_data", 8'(out_data), 8'h9);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 8'(out_valid), 8'h0);
      chk("async_rst_data", 8'(out_data), 8'h0);
      chk("async_rst_sel", 8'(sel), 8'h0);
      a_valid = 1'b0;
      #1 reset_n = 1'b1;
      #1;
      chk("idle_a_ready", 8'(a_ready), 8'h0);
      chk("idle_b_ready", 8'(b_ready), 8'h0);

      // Single source A.
      tick();
      a_valid = 1'b1; a_data = 4'h5; out_ready = 1'b1;
      #1;
      chk("single_a_ready", 8'(a_ready), 8'h1);
      chk("single_b_ready", 8'(b_ready), 8'h0);
      chk("single_sel", 8'(sel), 8'h0);
      tick();
      chk("single_out_valid", 8'(out_valid), 8'h1);
      chk("single_out_data", 8'(out_data), 8'h5);

      // Conflict round-robin from a fresh priority.
      reset_pulse();
      a_valid = 1'b1; a_data = 4'h3; b_valid = 1'b1; b_data = 4'hC;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("conf_sel%0d", i), 8'(sel), 8'(i % 2));
         tick();
         chk($sformatf("conf_data%0d", i), 8'(out_data), 8'(CONF_DATA[i]));
      end

      // Fill with A=A, then backpressure a pending B word.
      b_valid = 1'b0; a_data = 4'hA;
      #1;
      chk("bp_fill_sel", 8'(sel), 8'h0);
      tick();
      chk("bp_fill_data", 8'(out_data), 8'hA);
      a_valid = 1'b0; b_valid = 1'b1; b_data = 4'h6; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_b_ready%0d", i), 8'(b_ready), 8'h0);
         tick();
         chk($sformatf("bp_hold_data%0d", i), 8'(out_data), 8'hA);
         chk($sformatf("bp_hold_valid%0d", i), 8'(out_valid), 8'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_b_ready", 8'(b_ready), 8'h1);
      chk("bp_release_sel", 8'(sel), 8'h1);
      tick();
      chk("bp_nobubble_valid", 8'(out_valid), 8'h1);
      chk("bp_nobubble_data", 8'(out_data), 8'h6);

      // Idle hold: sel keeps last B, register drains once.
      b_valid = 1'b0;
      #1;
      chk("idle_sel", 8'(sel), 8'h1);
      tick();
      chk("idle_drain_valid", 8'(out_valid), 8'h0);
      chk("idle_drain_data", 8'(out_data), 8'h6);
      chk("idle_sel_after", 8'(sel), 8'h1);

`ifdef ARB_GRANT_COUNT_EN
      reset_pulse();
      chk("cnt_rst_a", a_grant_cnt, 8'h00);
      a_valid = 1'b1; a_data = 4'h1; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 9) chk("cnt_a_10", a_grant_cnt, 8'd10);
      end
      a_valid = 1'b0;
      tick();
      chk("cnt_a_sat", a_grant_cnt, 8'hFF);
      chk("cnt_b_zero", b_grant_cnt, 8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
